data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 93 +++++++++
 tb/tb_data_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter granting two requesters access to one data memory,
// with per-transaction ack timeout and a saturating timeout counter.
module data_mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic          err0,
    output logic          err1,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [7:0]    timeout_cnt
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    state_t state;
    logic last_grant, grant;
    logic [7:0] wait_cnt;
    logic elig0, elig1, pick1;
    // a requester whose ack is still high is not eligible, so a held req is not re-granted
    assign elig0 = req0 && !ack0;
    assign elig1 = req1 && !ack1;
    assign pick1 = elig1 && (!elig0 || !last_grant);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant       <= 1'b0;
            wait_cnt    <= 8'd0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            rdata       <= '0;
            timeout_cnt <= 8'd0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            if (state == IDLE) begin
                if (elig0 || elig1) begin
                    state      <= BUSY;
                    mem_en     <= 1'b1;
                    grant      <= pick1;
                    last_grant <= pick1;
                    wait_cnt   <= 8'd0;
                    mem_we     <= pick1 ? we1 : we0;
                    mem_addr   <= pick1 ? addr1 : addr0;
                    mem_wdata  <= pick1 ? wdata1 : wdata0;
                end
            end else if (mem_ack) begin
                state  <= IDLE;
                mem_en <= 1'b0;
                rdata  <= mem_rdata;
                ack0   <= !grant;
                ack1   <= grant;
            end else if (wait_cnt == WAIT_LAST) begin
                state  <= IDLE;
                mem_en <= 1'b0;
                rdata  <= '1;
                ack0   <= !grant;
                ack1   <= grant;
                err0   <= !grant;
                err1   <= grant;
                if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed vector table, hand sequences and a randomized run against
// a transaction-level reference model of the arbiter.
module tb_data_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TIMEOUT = 15;

    logic clk, reset;
    logic req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1, mem_addr;
    logic [DW-1:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;
    logic ack0, ack1, err0, err1, mem_en, mem_we, mem_ack;
    logic [7:0] timeout_cnt;

    int checks = 0;
    int errors = 0;

    data_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .timeout_cnt(timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id; logic we; logic [7:0] addr; logic [31:0] wdata; int k; logic [31:0] mrd;
        int en_cycles; logic err; logic [31:0] exp_rdata; int tcnt;
    } vec_t;

    typedef struct {int cycles; int mprob; int rprob;} blk_t;

    // reference model state
    int m_owner, m_wait, m_last, m_tcnt;
    logic m_ack[2], m_err[2];
    logic m_en, m_we;
    logic [7:0] m_addr;
    logic [31:0] m_wd, m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        bit done;
        if (v.id == 0) begin req0 = 1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; end
        else begin req1 = 1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; end
        tick();
        chk("grant_en", mem_en, 1);
        chk("grant_we", mem_we, v.we);
        chk("grant_addr", mem_addr, v.addr);
        chk("grant_wdata", mem_wdata, v.wdata);
        req0 = 0;
        req1 = 0;
        n = 0;
        done = 0;
        for (int i = 1; i <= 40 && !done; i++) begin
            if (mem_en) n++;
            if (i == v.k) begin mem_ack = 1; mem_rdata = v.mrd; end
            tick();
            mem_ack = 0;
            mem_rdata = $urandom;
            if (ack0 || ack1) done = 1;
            else if (mem_en) chk("busy_addr_stable", mem_addr, v.addr);
        end
        chk("vec_done", done, 1);
        chk("vec_en_cycles", n, v.en_cycles);
        chk("vec_ack0", ack0, v.id == 0);
        chk("vec_ack1", ack1, v.id == 1);
        chk("vec_err0", err0, v.id == 0 && v.err);
        chk("vec_err1", err1, v.id == 1 && v.err);
        chk("vec_rdata", rdata, v.exp_rdata);
        chk("vec_en_off", mem_en, 0);
        chk("vec_tcnt", timeout_cnt, v.tcnt);
        tick();
        chk("vec_ack_pulse", {ack0, ack1}, 0);
    endtask

    task automatic model_reset();
        m_owner = -1; m_wait = 0; m_last = 1; m_tcnt = 0;
        m_ack = '{1'b0, 1'b0}; m_err = '{1'b0, 1'b0};
        m_en = 0; m_we = 0; m_addr = 0; m_wd = 0; m_rd = 0;
    endtask

    // advances the model over one rising edge using the inputs currently driven
    task automatic model_step();
        logic r[2], w[2], el[2];
        logic [7:0] a[2];
        logic [31:0] d[2];
        int pick;
        r = '{req0, req1}; w = '{we0, we1}; a = '{addr0, addr1}; d = '{wdata0, wdata1};
        el[0] = r[0] && !m_ack[0];
        el[1] = r[1] && !m_ack[1];
        m_ack = '{1'b0, 1'b0};
        m_err = '{1'b0, 1'b0};
        if (m_owner >= 0) begin
            if (mem_ack) begin
                m_ack[m_owner] = 1; m_rd = mem_rdata; m_en = 0; m_owner = -1;
            end else if (m_wait + 1 == TIMEOUT) begin
                m_ack[m_owner] = 1; m_err[m_owner] = 1; m_rd = '1; m_en = 0; m_owner = -1;
                if (m_tcnt < 255) m_tcnt++;
            end else m_wait++;
        end else begin
            pick = (el[0] && el[1]) ? 1 - m_last : el[0] ? 0 : el[1] ? 1 : -1;
            if (pick >= 0) begin
                m_owner = pick; m_last = pick; m_wait = 0; m_en = 1;
                m_we = w[pick]; m_addr = a[pick]; m_wd = d[pick];
            end
        end
    endtask

    task automatic model_compare();
        chk("m_ack0", ack0, m_ack[0]);
        chk("m_ack1", ack1, m_ack[1]);
        chk("m_err0", err0, m_err[0]);
        chk("m_err1", err1, m_err[1]);
        chk("m_mem_en", mem_en, m_en);
        chk("m_tcnt", timeout_cnt, m_tcnt);
        if (m_en) begin
            chk("m_mem_we", mem_we, m_we);
            chk("m_mem_addr", mem_addr, m_addr);
            chk("m_mem_wdata", mem_wdata, m_wd);
        end
        if (m_ack[0] || m_ack[1]) chk("m_rdata", rdata, m_rd);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        vec_t v;
        blk_t blks[6];
        int g;
        vecs[0] = '{0, 1'b1, 8'h10, 32'hCAFEF00D, 3, 32'h0BADBEEF, 3, 1'b0, 32'h0BADBEEF, 0};
        vecs[1] = '{1, 1'b0, 8'h3F, 32'h00000000, 2, 32'h12345678, 2, 1'b0, 32'h12345678, 0};
        vecs[2] = '{0, 1'b0, 8'h20, 32'h00000000, 0, 32'h0,        15, 1'b1, 32'hFFFFFFFF, 1};
        vecs[3] = '{0, 1'b1, 8'h21, 32'h5555AAAA, 15, 32'hA5A5A5A5, 15, 1'b0, 32'hA5A5A5A5, 1};
        vecs[4] = '{1, 1'b1, 8'hFF, 32'h80000001, 1, 32'h00000001, 1, 1'b0, 32'h00000001, 1};
        vecs[5] = '{1, 1'b0, 8'h00, 32'h00000000, 0, 32'h0,        15, 1'b1, 32'hFFFFFFFF, 2};
        vecs[6] = '{0, 1'b0, 8'h7E, 32'h00000000, 14, 32'h13579BDF, 14, 1'b0, 32'h13579BDF, 2};
        blks[0] = '{600, 30, 40};
        blks[1] = '{600, 2, 40};
        blks[2] = '{600, 0, 30};
        blks[3] = '{600, 10, 60};
        blks[4] = '{4500, 0, 100};
        blks[5] = '{600, 40, 50};

        reset = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0;
        wdata0 = 0; wdata1 = 0; mem_ack = 0; mem_rdata = 0;
        @(negedge clk);
        tick();
        chk("rst_outputs", {ack0, ack1, err0, err1, mem_en, mem_we}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_tcnt", timeout_cnt, 0);
        reset = 1;
        tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // reset in the middle of a transaction, with a late mem_ack that must be ignored
        req0 = 1; we0 = 1; addr0 = 8'h44; wdata0 = 32'hFEEDFACE;
        tick();
        chk("mid_grant", mem_en, 1);
        req0 = 0;
        tick();
        #2 reset = 0;
        #1 chk("mid_rst_async_en", mem_en, 0);
        chk("mid_rst_async_addr", mem_addr, 0);
        mem_ack = 1;
        tick();
        reset = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_quiet", {ack0, ack1, mem_en}, 0);
        end
        mem_ack = 0;

        // both requesters held: alternate 0,1,0,1,0 starting with 0
        addr0 = 8'hA0; addr1 = 8'hB1; we0 = 0; we1 = 1; req0 = 1; req1 = 1; g = 0;
        for (int c = 0; c < 60 && g < 5; c++) begin
            tick();
            chk("arb_ack_excl", ack0 & ack1, 0);
            mem_ack = mem_en;
            if (mem_en) begin
                chk("arb_order", mem_addr == 8'hB1, g % 2);
                g++;
            end
        end
        chk("arb_count", g, 5);
        req0 = 0; req1 = 0;
        tick();
        mem_ack = 0;
        chk("arb_last_ack0", {ack0, ack1}, 2'b10);
        tick();
        tick();
        // last grant was 0, so a fresh tie goes to 1
        req0 = 1; req1 = 1;
        tick();
        chk("tie_en", mem_en, 1);
        chk("tie_addr", mem_addr, 8'hB1);
        req0 = 0; req1 = 0; mem_ack = 1; mem_rdata = 32'h600DF00D;
        tick();
        mem_ack = 0;
        chk("tie_ack", {ack0, ack1}, 2'b01);
        chk("tie_rdata", rdata, 32'h600DF00D);
        tick();

        // randomized run against the reference model
        reset = 0;
        tick();
        reset = 1;
        model_reset();
        for (int b = 0; b < 6; b++) begin
            for (int c = 0; c < blks[b].cycles; c++) begin
                req0 = $urandom_range(0, 99) < blks[b].rprob;
                req1 = $urandom_range(0, 99) < blks[b].rprob;
                we0 = 1'($urandom); we1 = 1'($urandom);
                addr0 = 8'($urandom); addr1 = 8'($urandom);
                wdata0 = $urandom; wdata1 = $urandom;
                mem_ack = $urandom_range(0, 99) < blks[b].mprob;
                mem_rdata = $urandom;
                model_step();
                tick();
                model_compare();
                chk("rand_ack_excl", ack0 & ack1, 0);
            end
            if (b == 4) chk("tcnt_saturated", timeout_cnt, 255);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
